// File: rtl/famicom_pkg.sv
// Shared types, button bit positions and wire-byte helper for the famicom input scheduler.
package famicom_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } key_state_t;

    localparam int BTN_R       = 0;
    localparam int BTN_L       = 1;
    localparam int BTN_D       = 2;
    localparam int BTN_U       = 3;
    localparam int BTN_A       = 4;
    localparam int BTN_B       = 5;
    localparam int BTN_SEL     = 6;
    localparam int BTN_START   = 7;
    localparam int BTN_TURBO_A = 8;
    localparam int BTN_TURBO_B = 9;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    // Controller shifts A first; buttons are active-low on the wire.
    function automatic logic [7:0] pad_to_wire(input logic [7:0] btn);
        return ~{btn[BTN_A], btn[BTN_B], btn[BTN_SEL], btn[BTN_START],
                 btn[BTN_U], btn[BTN_D], btn[BTN_L], btn[BTN_R]};
    endfunction

endpackage

// File: rtl/famicom_key_fifo.sv
// Small synchronous FIFO holding pending keyboard ASCII codes; pointers wrap mod DEPTH.
module famicom_key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/famicom_input_scheduler.sv
// Gigatron famicom serial input: joystick/keyboard arbitration, key hold/gap scheduling, shift out.
// Optional build macro AUTOFIRE_EN adds turbo A/B driven by a frame-count phase.
//   state  | meaning
//   S_IDLE | no key presented; pops the next key on a frame event
//   S_HOLD | key_reg presented for HOLD_FRAMES frames
//   S_GAP  | idle byte presented for GAP_FRAMES frames so repeats separate
module famicom_input_scheduler
    import famicom_pkg::*;
#(
    parameter int KEYQ_DEPTH   = 8,
    parameter int HOLD_FRAMES  = 3,
    parameter int GAP_FRAMES   = 2,
    parameter int AUTOFIRE_DIV = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] joystick,
    input  logic [7:0]  kbd_ascii,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    input  logic        famicom_latch,
    input  logic        famicom_pulse,
    output logic        famicom_data,
    output logic        key_busy,
    output logic        kbd_overflow
);

    localparam int CNT_MAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]       latch_sync;
    logic [1:0]       pulse_sync;
    logic             latch_d;
    logic             pulse_d;
    logic             latch_s;
    logic             frame_evt;
    logic             pulse_rise;

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       key_reg;
    logic [7:0]       sreg;

    logic [7:0]       pad_btn;
    logic             pad_active;
    logic [7:0]       key_byte;
    logic [7:0]       wire_byte;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            latch_sync <= '0;
            pulse_sync <= '0;
            latch_d    <= 1'b0;
            pulse_d    <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[0], famicom_latch};
            pulse_sync <= {pulse_sync[0], famicom_pulse};
            latch_d    <= latch_sync[1];
            pulse_d    <= pulse_sync[1];
        end
    end

    assign latch_s    = latch_sync[1];
    assign frame_evt  = latch_s && !latch_d;
    assign pulse_rise = pulse_sync[1] && !pulse_d;

`ifdef AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [AF_W-1:0] af_cnt;
    logic            af_phase;
    logic            unused_joy;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (frame_evt) begin
            if (af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pad_btn        = joystick[7:0];
        pad_btn[BTN_A] = joystick[BTN_A] | (joystick[BTN_TURBO_A] & af_phase);
        pad_btn[BTN_B] = joystick[BTN_B] | (joystick[BTN_TURBO_B] & af_phase);
    end

    assign pad_active = |joystick[9:0];
    assign unused_joy = ^joystick[31:10];
`else
    logic unused_joy;

    assign pad_btn    = joystick[7:0];
    assign pad_active = |joystick[7:0];
    assign unused_joy = ^{joystick[31:8], AUTOFIRE_DIV[0]};
`endif

    // 8'hFF is the idle byte on the wire, so it can never be queued as a key.
    assign fifo_push = kbd_valid && (kbd_ascii != IDLE_BYTE);
    assign fifo_pop  = frame_evt && !pad_active && (state == S_IDLE) && !fifo_empty;

    famicom_key_fifo #(
        .DEPTH (KEYQ_DEPTH)
    ) u_key_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (kbd_ascii),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            kbd_overflow <= 1'b0;
        end else if (kbd_valid && fifo_full) begin
            kbd_overflow <= 1'b1;
        end
    end

    // Pad activity freezes the scheduler so a held key is not lost under joystick use.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            key_reg <= IDLE_BYTE;
        end else if (frame_evt && !pad_active) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        key_reg <= fifo_dout;
                        cnt     <= '0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_FRAMES - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_byte  = (state == S_HOLD) ? key_reg : IDLE_BYTE;
    assign wire_byte = pad_active ? pad_to_wire(pad_btn) : key_byte;

    // Loading continues through the whole latch pulse so the post-transition byte is what ships.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= IDLE_BYTE;
        end else if (latch_s) begin
            sreg <= wire_byte;
        end else if (pulse_rise) begin
            sreg <= {sreg[6:0], 1'b1};
        end
    end

    assign famicom_data = sreg[7];
    assign kbd_ready    = !fifo_full;
    assign key_busy     = (state != S_IDLE) || !fifo_empty;

endmodule
